// File: rtl/control_multiciclo_pkg.sv
// control_multiciclo_pkg: state, opcode, ALU-mode and mux-select encodings shared by the multicycle control unit.
package control_multiciclo_pkg;
  typedef enum logic [3:0] {
    INICIO   = 4'd0,
    FETCH    = 4'd1,
    DECODE   = 4'd2,
    EXEC_R   = 4'd3,
    EXEC_I   = 4'd4,
    MEM_DIR  = 4'd5,
    MEM_LEER = 4'd6,
    MEM_ESCR = 4'd7,
    WB_ALU   = 4'd8,
    WB_MEM   = 4'd9,
    SALTO    = 4'd10,
    JAL      = 4'd11,
    JALR     = 4'd12,
    LUI      = 4'd13,
    AUIPC    = 4'd14,
    ERROR    = 4'd15
  } estado_t;
  localparam logic [6:0] OP_LOAD   = 7'd3;
  localparam logic [6:0] OP_IMM    = 7'd19;
  localparam logic [6:0] OP_AUIPC  = 7'd23;
  localparam logic [6:0] OP_STORE  = 7'd35;
  localparam logic [6:0] OP_REG    = 7'd51;
  localparam logic [6:0] OP_LUI    = 7'd55;
  localparam logic [6:0] OP_BRANCH = 7'd99;
  localparam logic [6:0] OP_JALR   = 7'd103;
  localparam logic [6:0] OP_JAL    = 7'd111;
  localparam logic [1:0] MODO_ADD    = 2'b00;
  localparam logic [1:0] MODO_OPIMM  = 2'b01;
  localparam logic [1:0] MODO_OP     = 2'b10;
  localparam logic [1:0] MODO_BRANCH = 2'b11;
  localparam logic [1:0] A_PC     = 2'b00;
  localparam logic [1:0] A_RS1    = 2'b01;
  localparam logic [1:0] A_PC_ANT = 2'b10;
  localparam logic [1:0] A_CERO   = 2'b11;
  localparam logic [1:0] B_RS2    = 2'b00;
  localparam logic [1:0] B_IMM    = 2'b01;
  localparam logic [1:0] B_CUATRO = 2'b10;
  localparam logic [1:0] DATO_ALUOUT = 2'b00;
  localparam logic [1:0] DATO_MEM    = 2'b01;
  localparam logic [1:0] DATO_PC     = 2'b10;
  localparam logic [1:0] DATO_IMM    = 2'b11;
  // funct3 010/011 are not defined branch conditions
  function automatic logic salto_invalido(input logic [2:0] f);
    return f[2:1] == 2'b01;
  endfunction
endpackage

// File: rtl/control_multiciclo_decodificador_opcode.sv
// decodificador_opcode: maps the IR opcode to the state that follows DECODE.
module decodificador_opcode
  import control_multiciclo_pkg::*;
(
  input  logic [6:0] opcode_i,
  output estado_t    estado_o
);
  always_comb begin
    case (opcode_i)
      OP_REG:    estado_o = EXEC_R;
      OP_IMM:    estado_o = EXEC_I;
      OP_LOAD:   estado_o = MEM_DIR;
      OP_STORE:  estado_o = MEM_DIR;
      OP_BRANCH: estado_o = SALTO;
      OP_JAL:    estado_o = JAL;
      OP_JALR:   estado_o = JALR;
      OP_LUI:    estado_o = LUI;
      OP_AUIPC:  estado_o = AUIPC;
      default:   estado_o = ERROR;
    endcase
  end
endmodule

// File: rtl/control_multiciclo.sv
// control_multiciclo: multicycle RV32I control FSM; outputs decode the state register plus mem_listo/cond_salto.
module control_multiciclo
  import control_multiciclo_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       cond_salto,
  input  logic       mem_listo,
  output logic       mem_valido,
  output logic       mem_escr,
  output logic       sel_dir,
  output logic       escr_ir,
  output logic       escr_pc,
  output logic       escr_pc_ant,
  output logic       escr_reg,
  output logic       sel_pc,
  output logic [1:0] sel_alu_a,
  output logic [1:0] sel_alu_b,
  output logic [1:0] sel_reg_dato,
  output logic [1:0] modo,
  output logic [3:0] estado,
  output logic       error
);
  estado_t estado_q, estado_d, estado_dec;
  decodificador_opcode u_dec (
    .opcode_i(opcode),
    .estado_o(estado_dec)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) estado_q <= INICIO;
    else estado_q <= estado_d;
  assign estado = estado_q;
  // Outputs react to mem_listo/cond_salto in the same cycle so a zero-wait access costs no extra state
  always_comb begin
    estado_d     = estado_q;
    mem_valido   = 1'b0;
    mem_escr     = 1'b0;
    sel_dir      = 1'b0;
    escr_ir      = 1'b0;
    escr_pc      = 1'b0;
    escr_pc_ant  = 1'b0;
    escr_reg     = 1'b0;
    sel_pc       = 1'b0;
    sel_alu_a    = A_PC;
    sel_alu_b    = B_RS2;
    sel_reg_dato = DATO_ALUOUT;
    modo         = MODO_ADD;
    error        = 1'b0;
    case (estado_q)
      INICIO: estado_d = FETCH;
      FETCH: begin
        mem_valido  = 1'b1;
        sel_alu_b   = B_CUATRO;
        escr_ir     = mem_listo;
        escr_pc     = mem_listo;
        escr_pc_ant = mem_listo;
        estado_d    = mem_listo ? DECODE : FETCH;
      end
      DECODE: begin
        sel_alu_a = A_PC_ANT;
        sel_alu_b = B_IMM;
        estado_d  = estado_dec;
      end
      EXEC_R: begin
        sel_alu_a = A_RS1;
        modo      = MODO_OP;
        estado_d  = WB_ALU;
      end
      EXEC_I: begin
        sel_alu_a = A_RS1;
        sel_alu_b = B_IMM;
        modo      = MODO_OPIMM;
        estado_d  = WB_ALU;
      end
      MEM_DIR: begin
        sel_alu_a = A_RS1;
        sel_alu_b = B_IMM;
        estado_d  = opcode == OP_LOAD ? MEM_LEER : MEM_ESCR;
      end
      MEM_LEER: begin
        mem_valido = 1'b1;
        sel_dir    = 1'b1;
        estado_d   = mem_listo ? WB_MEM : MEM_LEER;
      end
      MEM_ESCR: begin
        mem_valido = 1'b1;
        sel_dir    = 1'b1;
        mem_escr   = 1'b1;
        estado_d   = mem_listo ? FETCH : MEM_ESCR;
      end
      WB_ALU: begin
        escr_reg = 1'b1;
        estado_d = FETCH;
      end
      WB_MEM: begin
        escr_reg     = 1'b1;
        sel_reg_dato = DATO_MEM;
        estado_d     = FETCH;
      end
      SALTO: begin
        if (salto_invalido(funct3)) estado_d = ERROR;
        else begin
          sel_alu_a = A_RS1;
          modo      = MODO_BRANCH;
          escr_pc   = cond_salto;
          sel_pc    = 1'b1;
          estado_d  = FETCH;
        end
      end
      JAL: begin
        escr_reg     = 1'b1;
        sel_reg_dato = DATO_PC;
        escr_pc      = 1'b1;
        sel_pc       = 1'b1;
        estado_d     = FETCH;
      end
      JALR: begin
        sel_alu_a    = A_RS1;
        sel_alu_b    = B_IMM;
        escr_pc      = 1'b1;
        escr_reg     = 1'b1;
        sel_reg_dato = DATO_PC;
        estado_d     = FETCH;
      end
      LUI: begin
        escr_reg     = 1'b1;
        sel_reg_dato = DATO_IMM;
        estado_d     = FETCH;
      end
      AUIPC: begin
        escr_reg = 1'b1;
        estado_d = FETCH;
      end
      ERROR: error = 1'b1;
      default: estado_d = ERROR;
    endcase
  end
endmodule

// File: tb/tb_control_multiciclo.sv
// tb_control_multiciclo: directed instruction sequences; expected per-cycle outputs queued, checked by a negedge monitor.
module tb_control_multiciclo;
  import control_multiciclo_pkg::*;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] opcode = 7'd0;
  logic [2:0] funct3 = 3'd0;
  logic       cond_salto = 1'b0;
  logic       mem_listo = 1'b0;
  logic       mem_valido, mem_escr, sel_dir, escr_ir, escr_pc, escr_pc_ant, escr_reg, sel_pc, error;
  logic [1:0] sel_alu_a, sel_alu_b, sel_reg_dato, modo;
  logic [3:0] estado;
  int checks = 0;
  int failures = 0;
  logic [20:0] exp_q[$];
  string       name_q[$];
  control_multiciclo dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .cond_salto(cond_salto),
    .mem_listo(mem_listo), .mem_valido(mem_valido), .mem_escr(mem_escr), .sel_dir(sel_dir),
    .escr_ir(escr_ir), .escr_pc(escr_pc), .escr_pc_ant(escr_pc_ant), .escr_reg(escr_reg),
    .sel_pc(sel_pc), .sel_alu_a(sel_alu_a), .sel_alu_b(sel_alu_b), .sel_reg_dato(sel_reg_dato),
    .modo(modo), .estado(estado), .error(error)
  );
  always #5 clk = ~clk;
  // f = {mem_valido, mem_escr, sel_dir, escr_ir, escr_pc, escr_pc_ant, escr_reg, sel_pc}
  function automatic logic [20:0] mk(input logic [3:0] st, input logic [7:0] f, input logic [1:0] a,
                                     input logic [1:0] b, input logic [1:0] rd, input logic [1:0] mo,
                                     input logic er);
    return {st, f, a, b, rd, mo, er};
  endfunction
  localparam logic [20:0] X_INI = mk(INICIO,   8'b0000_0000, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
  localparam logic [20:0] X_FW  = mk(FETCH,    8'b1000_0000, 2'b00, 2'b10, 2'b00, 2'b00, 1'b0);
  localparam logic [20:0] X_FG  = mk(FETCH,    8'b1001_1100, 2'b00, 2'b10, 2'b00, 2'b00, 1'b0);
  localparam logic [20:0] X_DEC = mk(DECODE,   8'b0000_0000, 2'b10, 2'b01, 2'b00, 2'b00, 1'b0);
  localparam logic [20:0] X_XR  = mk(EXEC_R,   8'b0000_0000, 2'b01, 2'b00, 2'b00, 2'b10, 1'b0);
  localparam logic [20:0] X_XI  = mk(EXEC_I,   8'b0000_0000, 2'b01, 2'b01, 2'b00, 2'b01, 1'b0);
  localparam logic [20:0] X_MD  = mk(MEM_DIR,  8'b0000_0000, 2'b01, 2'b01, 2'b00, 2'b00, 1'b0);
  localparam logic [20:0] X_ML  = mk(MEM_LEER, 8'b1010_0000, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
  localparam logic [20:0] X_ME  = mk(MEM_ESCR, 8'b1110_0000, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
  localparam logic [20:0] X_WA  = mk(WB_ALU,   8'b0000_0010, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
  localparam logic [20:0] X_WM  = mk(WB_MEM,   8'b0000_0010, 2'b00, 2'b00, 2'b01, 2'b00, 1'b0);
  localparam logic [20:0] X_ST  = mk(SALTO,    8'b0000_1001, 2'b01, 2'b00, 2'b00, 2'b11, 1'b0);
  localparam logic [20:0] X_SN  = mk(SALTO,    8'b0000_0001, 2'b01, 2'b00, 2'b00, 2'b11, 1'b0);
  localparam logic [20:0] X_SB  = mk(SALTO,    8'b0000_0000, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
  localparam logic [20:0] X_JL  = mk(JAL,      8'b0000_1011, 2'b00, 2'b00, 2'b10, 2'b00, 1'b0);
  localparam logic [20:0] X_JR  = mk(JALR,     8'b0000_1010, 2'b01, 2'b01, 2'b10, 2'b00, 1'b0);
  localparam logic [20:0] X_LU  = mk(LUI,      8'b0000_0010, 2'b00, 2'b00, 2'b11, 2'b00, 1'b0);
  localparam logic [20:0] X_AU  = mk(AUIPC,    8'b0000_0010, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
  localparam logic [20:0] X_ER  = mk(ERROR,    8'b0000_0000, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1);
  task automatic push(input logic [20:0] e, input string n);
    exp_q.push_back(e);
    name_q.push_back(n);
  endtask
  task automatic cyc(input logic [20:0] e, input string n, input logic ml);
    mem_listo = ml;
    push(e, n);
    @(posedge clk);
    #1;
  endtask
  task automatic reset_pulse(input string n);
    reset = 1'b1;
    push(X_INI, {n, "_async"});
    @(posedge clk);
    #1;
    reset = 1'b0;
    mem_listo = 1'b0;
    push(X_INI, {n, "_inicio"});
    @(posedge clk);
    #1;
  endtask
  initial begin : monitor
    logic [20:0] act, e;
    string n;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n = name_q.pop_front();
        act = {estado, mem_valido, mem_escr, sel_dir, escr_ir, escr_pc, escr_pc_ant, escr_reg, sel_pc,
               sel_alu_a, sel_alu_b, sel_reg_dato, modo, error};
        checks++;
        if (act !== e) begin
          failures++;
          $display("FAIL %s: got st=%0d ctl=%b a=%b b=%b rd=%b modo=%b err=%b, want st=%0d ctl=%b a=%b b=%b rd=%b modo=%b err=%b",
                   n, act[20:17], act[16:9], act[8:7], act[6:5], act[4:3], act[2:1], act[0],
                   e[20:17], e[16:9], e[8:7], e[6:5], e[4:3], e[2:1], e[0]);
        end
      end
    end
  end
  initial begin : stim
    @(posedge clk);
    #1;
    cyc(X_INI, "reset_held", 1'b0);
    reset = 1'b0;
    cyc(X_INI, "inicio_after_release", 1'b0);
    opcode = OP_REG;
    cyc(X_FG, "r_fetch", 1'b1);
    cyc(X_DEC, "r_decode", 1'b0);
    cyc(X_XR, "r_exec", 1'b0);
    cyc(X_WA, "r_wb", 1'b0);
    opcode = OP_IMM;
    cyc(X_FG, "i_fetch", 1'b1);
    cyc(X_DEC, "i_decode", 1'b0);
    cyc(X_XI, "i_exec", 1'b0);
    cyc(X_WA, "i_wb", 1'b0);
    opcode = OP_LOAD;
    cyc(X_FG, "ld_fetch", 1'b1);
    cyc(X_DEC, "ld_decode", 1'b0);
    cyc(X_MD, "ld_dir", 1'b0);
    for (int i = 0; i < 3; i++) cyc(X_ML, "ld_wait", 1'b0);
    cyc(X_ML, "ld_done", 1'b1);
    cyc(X_WM, "ld_wb", 1'b0);
    opcode = OP_STORE;
    cyc(X_FW, "st_fetch_wait", 1'b0);
    cyc(X_FW, "st_fetch_wait", 1'b0);
    cyc(X_FG, "st_fetch", 1'b1);
    cyc(X_DEC, "st_decode", 1'b0);
    cyc(X_MD, "st_dir", 1'b0);
    cyc(X_ME, "st_write", 1'b1);
    opcode = OP_BRANCH;
    funct3 = 3'b000;
    cond_salto = 1'b1;
    cyc(X_FG, "beq_t_fetch", 1'b1);
    cyc(X_DEC, "beq_t_decode", 1'b0);
    cyc(X_ST, "beq_taken", 1'b0);
    cond_salto = 1'b0;
    cyc(X_FG, "beq_n_fetch", 1'b1);
    cyc(X_DEC, "beq_n_decode", 1'b0);
    cyc(X_SN, "beq_not_taken", 1'b0);
    opcode = OP_JAL;
    cyc(X_FG, "jal_fetch", 1'b1);
    cyc(X_DEC, "jal_decode", 1'b0);
    cyc(X_JL, "jal", 1'b0);
    opcode = OP_JALR;
    cyc(X_FG, "jalr_fetch", 1'b1);
    cyc(X_DEC, "jalr_decode", 1'b0);
    cyc(X_JR, "jalr", 1'b0);
    opcode = OP_LUI;
    cyc(X_FG, "lui_fetch", 1'b1);
    cyc(X_DEC, "lui_decode", 1'b0);
    cyc(X_LU, "lui", 1'b0);
    opcode = OP_AUIPC;
    cyc(X_FG, "auipc_fetch", 1'b1);
    cyc(X_DEC, "auipc_decode", 1'b0);
    cyc(X_AU, "auipc", 1'b0);
    opcode = OP_BRANCH;
    funct3 = 3'b010;
    cond_salto = 1'b1;
    cyc(X_FG, "bad_br_fetch", 1'b1);
    cyc(X_DEC, "bad_br_decode", 1'b0);
    cyc(X_SB, "bad_br_salto", 1'b0);
    for (int i = 0; i < 3; i++) cyc(X_ER, "bad_br_error", 1'b1);
    reset_pulse("rst_from_error");
    opcode = 7'd115;
    cond_salto = 1'b0;
    cyc(X_FG, "illegal_fetch", 1'b1);
    cyc(X_DEC, "illegal_decode", 1'b0);
    for (int i = 0; i < 10; i++) cyc(X_ER, "illegal_error_hold", 1'b1);
    reset_pulse("rst_illegal");
    opcode = OP_REG;
    cyc(X_FW, "abort_fetch_wait", 1'b0);
    reset_pulse("rst_mid_fetch");
    cyc(X_FG, "post_rst_fetch", 1'b1);
    cyc(X_DEC, "post_rst_decode", 1'b0);
    cyc(X_XR, "post_rst_exec", 1'b0);
    cyc(X_WA, "post_rst_wb", 1'b0);
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end
    @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got timeout at %0t, want completion", $time);
    $fatal(1, "timeout");
  end
endmodule
